// File: rtl/yarp_pkg.sv
// yarp_pkg: instruction types, opcode constants and field bundle shared by the yarp front end.
package yarp_pkg;

    typedef enum logic [2:0] {TYPE_R, TYPE_I, TYPE_S, TYPE_B, TYPE_U, TYPE_J} instr_type_t;

    localparam logic [6:0] R_type  = 7'h33;
    localparam logic [6:0] I_type1 = 7'h03;
    localparam logic [6:0] I_type2 = 7'h13;
    localparam logic [6:0] I_type3 = 7'h67;
    localparam logic [6:0] S_type  = 7'h23;
    localparam logic [6:0] B_type  = 7'h63;
    localparam logic [6:0] U_type1 = 7'h37;
    localparam logic [6:0] U_type2 = 7'h17;
    localparam logic [6:0] J_type  = 7'h6F;

    typedef struct packed {
        instr_type_t typ;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fields_t;

    // True when v[31:lsb] are all copies of one bit, i.e. v fits a signed field of lsb+1 bits.
    function automatic logic sext_ok(logic [31:0] v, int lsb);
        logic [31:0] s;
        s = $signed(v) >>> lsb;
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/yarp_encode_pack.sv
// yarp_encode_pack: packs a field bundle into a 32-bit instruction word and judges its legality.
module yarp_encode_pack
    import yarp_pkg::*;
(
    input  fields_t     f,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (f.typ)
            TYPE_R: begin
                word  = {f.f7, f.rs2, f.rs1, f.f3, f.rd, f.op};
                legal = f.op == R_type;
            end
            TYPE_I: begin
                word  = {f.imm[11:0], f.rs1, f.f3, f.rd, f.op};
                legal = (f.op == I_type1 || f.op == I_type2 || f.op == I_type3) && sext_ok(f.imm, 11);
            end
            TYPE_S: begin
                word  = {f.imm[11:5], f.rs2, f.rs1, f.f3, f.imm[4:0], f.op};
                legal = f.op == S_type && sext_ok(f.imm, 11);
            end
            TYPE_B: begin
                word  = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.f3, f.imm[4:1], f.imm[11], f.op};
                legal = f.op == B_type && !f.imm[0] && sext_ok(f.imm, 12);
            end
            TYPE_U: begin
                word  = {f.imm[31:12], f.rd, f.op};
                legal = (f.op == U_type1 || f.op == U_type2) && f.imm[11:0] == '0;
            end
            TYPE_J: begin
                word  = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.op};
                legal = f.op == J_type && !f.imm[0] && sext_ok(f.imm, 20);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/yarp_encode.sv
// yarp_encode: two-stage instruction encoder feeding an imem writer, with address and error counters.
module yarp_encode
    import yarp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [2:0]  type_i,
    input  logic [6:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    input  logic        load_i,
    input  logic [31:0] base_addr_i,
    input  logic        err_clr_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic        err_o,
    output logic [7:0]  err_cnt_o,
    output logic [15:0] enc_cnt_o
);

    fields_t     s1;
    logic        s1_valid, s2_valid;
    logic [31:0] s2_instr, s2_addr, addr_cnt, addr_next, word;
    logic        legal, out_hs, s1_adv, to_s2, discard;
    logic        err;
    logic [7:0]  err_cnt;
    logic [15:0] enc_cnt;

    yarp_encode_pack u_pack (.f(s1), .word(word), .legal(legal));

    assign out_hs    = s2_valid & instr_ready_i;
    assign s1_adv    = !s2_valid | out_hs | !legal;
    assign ready_o   = !s1_valid | s1_adv;
    assign to_s2     = s1_valid & legal & s1_adv;
    assign discard   = s1_valid & !legal;
    // A word entering S2 takes the address it will be written to, after this cycle's load or handshake.
    assign addr_next = load_i ? base_addr_i : out_hs ? addr_cnt + 32'd4 : addr_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1       <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_addr  <= '0;
            addr_cnt <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
            enc_cnt  <= '0;
        end else begin
            if (ready_o) s1_valid <= valid_i;
            if (valid_i && ready_o) s1 <= {type_i, op_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i};
            if (to_s2) begin
                s2_valid <= 1'b1;
                s2_instr <= word;
                s2_addr  <= addr_next;
            end else if (out_hs) begin
                s2_valid <= 1'b0;
            end
            addr_cnt <= addr_next;
            enc_cnt  <= enc_cnt + {15'd0, out_hs};
            err      <= discard | (err & !err_clr_i);
            err_cnt  <= discard ? (err_clr_i ? 8'd1 : err_cnt + {7'd0, err_cnt != 8'hFF})
                      : err_clr_i ? 8'd0 : err_cnt;
        end
    end

    assign instr_o       = s2_instr;
    assign instr_addr_o  = s2_addr;
    assign instr_valid_o = s2_valid;
    assign err_o         = err;
    assign err_cnt_o     = err_cnt;
    assign enc_cnt_o     = enc_cnt;

endmodule

// File: tb/tb_yarp_encode.sv
// tb_yarp_encode: randomized and directed checks of yarp_encode against a range-based reference model.
module tb_yarp_encode;

    logic        clk = 1'b0, reset = 1'b1;
    logic        valid_i = 1'b0, ready_o;
    logic [2:0]  type_i = '0;
    logic [6:0]  op_i = '0, funct7_i = '0;
    logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] imm_i = '0, base_addr_i = '0;
    logic        load_i = 1'b0, err_clr_i = 1'b0, instr_ready_i = 1'b1;
    logic [31:0] instr_o, instr_addr_o;
    logic        instr_valid_o, err_o;
    logic [7:0]  err_cnt_o;
    logic [15:0] enc_cnt_o;

    yarp_encode dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
        .type_i(type_i), .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
        .load_i(load_i), .base_addr_i(base_addr_i), .err_clr_i(err_clr_i),
        .instr_o(instr_o), .instr_addr_o(instr_addr_o), .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i), .err_o(err_o), .err_cnt_o(err_cnt_o), .enc_cnt_o(enc_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } bundle_t;

    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
    } out_t;

    out_t        exp_q[$], got_q[$];
    int          checks = 0, passed = 0;
    int          exp_enc = 0, exp_err = 0;
    logic [31:0] exp_addr = '0;

    // Records every word the consumer will take at the coming rising edge.
    always @(negedge clk)
        if (!reset && instr_valid_o && instr_ready_i) got_q.push_back('{instr_o, instr_addr_o});

    function automatic bundle_t mk(logic [2:0] t, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                                   logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7, logic [31:0] imm);
        bundle_t b;
        b.t = t; b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = f3; b.f7 = f7; b.imm = imm;
        return b;
    endfunction

    function automatic bit model_legal(bundle_t b);
        int v;
        v = b.imm;
        case (b.t)
            3'd0: return b.op == 7'h33;
            3'd1: return (b.op == 7'h03 || b.op == 7'h13 || b.op == 7'h67) && v >= -2048 && v <= 2047;
            3'd2: return b.op == 7'h23 && v >= -2048 && v <= 2047;
            3'd3: return b.op == 7'h63 && v % 2 == 0 && v >= -4096 && v <= 4095;
            3'd4: return (b.op == 7'h37 || b.op == 7'h17) && b.imm % 4096 == 0;
            3'd5: return b.op == 7'h6F && v % 2 == 0 && v >= -(1 << 20) && v < (1 << 20);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_word(bundle_t b);
        logic [31:0] i;
        i = b.imm;
        case (b.t)
            3'd0: return {b.f7, b.rs2, b.rs1, b.f3, b.rd, b.op};
            3'd1: return {i[11:0], b.rs1, b.f3, b.rd, b.op};
            3'd2: return {i[11:5], b.rs2, b.rs1, b.f3, i[4:0], b.op};
            3'd3: return {i[12], i[10:5], b.rs2, b.rs1, b.f3, i[4:1], i[11], b.op};
            3'd4: return {i[31:12], b.rd, b.op};
            default: return {i[20], i[10:1], i[11], i[19:12], b.rd, b.op};
        endcase
    endfunction

    function automatic void on_accept(bundle_t b);
        if (model_legal(b)) begin
            exp_q.push_back('{model_word(b), exp_addr});
            exp_addr = exp_addr + 32'd4;
            exp_enc++;
        end else begin
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t     b;
        logic [6:0]  iops[3] = '{7'h03, 7'h13, 7'h67};
        logic [6:0]  uops[2] = '{7'h37, 7'h17};
        b.t   = ($urandom_range(0, 99) < 6) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
        b.rd  = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
        b.f3  = 3'($urandom); b.f7  = 7'($urandom);
        case (b.t)
            3'd0: begin b.op = 7'h33; b.imm = $urandom; end
            3'd1: begin b.op = iops[$urandom_range(0, 2)]; b.imm = 32'(int'($urandom_range(0, 4095)) - 2048); end
            3'd2: begin b.op = 7'h23; b.imm = 32'(int'($urandom_range(0, 4095)) - 2048); end
            3'd3: begin b.op = 7'h63; b.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2); end
            3'd4: begin b.op = uops[$urandom_range(0, 1)]; b.imm = $urandom & 32'hFFFFF000; end
            default: begin b.op = 7'h6F; b.imm = 32'((int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2); end
        endcase
        if ($urandom_range(0, 99) < 8) b.op = 7'($urandom);
        if ($urandom_range(0, 99) < 10) b.imm = $urandom;
        return b;
    endfunction

    task automatic apply(bundle_t b);
        valid_i = 1'b1; type_i = b.t; op_i = b.op; rd_i = b.rd; rs1_i = b.rs1; rs2_i = b.rs2;
        funct3_i = b.f3; funct7_i = b.f7; imm_i = b.imm;
    endtask

    task automatic accept_one(bundle_t b);
        bit acc = 1'b0;
        apply(b);
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk); acc = ready_o;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        checks++;
        if (!acc) $display("FAIL accept_one: ready_o got 0 want 1 within 20 cycles");
        else begin passed++; on_accept(b); end
    endtask

    task automatic drive_stream(input bundle_t q[$], input int rdy_pct, output int cyc);
        int i = 0;
        bit acc;
        cyc = 0;
        while (i < q.size() && cyc < 5000) begin
            apply(q[i]);
            instr_ready_i = ($urandom_range(0, 99) < rdy_pct);
            @(negedge clk); acc = ready_o;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin on_accept(q[i]); i++; end
        end
        valid_i = 1'b0;
        checks++;
        if (i != q.size()) $display("FAIL stream_accepts: got %0d want %0d", i, q.size());
        else passed++;
    endtask

    task automatic check_scoreboard(string name);
        int n;
        valid_i = 1'b0; instr_ready_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != exp_q.size())
            $display("FAIL %s_count: got %0d words want %0d", name, got_q.size(), exp_q.size());
        else passed++;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i].w !== exp_q[i].w || got_q[i].a !== exp_q[i].a)
                $display("FAIL %s_word%0d: got %h@%h want %h@%h", name, i, got_q[i].w, got_q[i].a, exp_q[i].w, exp_q[i].a);
            else passed++;
        end
        checks++;
        if (enc_cnt_o !== 16'(exp_enc)) $display("FAIL %s_enc_cnt: got %0d want %0d", name, enc_cnt_o, 16'(exp_enc));
        else passed++;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(string name);
        checks++;
        if (instr_valid_o !== 1'b0 || instr_o !== '0 || instr_addr_o !== '0 || ready_o !== 1'b1 ||
            err_o !== 1'b0 || err_cnt_o !== '0 || enc_cnt_o !== '0)
            $display("FAIL %s: got v=%b i=%h a=%h rdy=%b e=%b ec=%0d enc=%0d want v=0 i=0 a=0 rdy=1 e=0 ec=0 enc=0",
                     name, instr_valid_o, instr_o, instr_addr_o, ready_o, err_o, err_cnt_o, enc_cnt_o);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed(string name, bundle_t b, logic [31:0] want);
        instr_ready_i = 1'b1;
        accept_one(b);
        checks++;
        if (instr_valid_o !== 1'b0) $display("FAIL %s_early: instr_valid_o got %b want 0", name, instr_valid_o);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (instr_valid_o !== 1'b1 || instr_o !== want)
            $display("FAIL %s_word: got v=%b %h want v=1 %h", name, instr_valid_o, instr_o, want);
        else passed++;
        check_scoreboard(name);
    endtask

    task automatic test_illegal();
        bundle_t b;
        bit seen = 1'b0;
        b = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        accept_one(b);
        repeat (3) begin
            @(posedge clk); #1;
            seen |= instr_valid_o;
        end
        checks++;
        if (seen || err_o !== 1'b1 || err_cnt_o !== 8'd1)
            $display("FAIL illegal_discard: got v=%b e=%b ec=%0d want v=0 e=1 ec=1", seen, err_o, err_cnt_o);
        else passed++;
        accept_one(b);
        err_clr_i = 1'b1;
        @(posedge clk); #1;
        err_clr_i = 1'b0;
        exp_err = 1;
        checks++;
        if (err_o !== 1'b1 || err_cnt_o !== 8'd1)
            $display("FAIL clear_vs_discard: got e=%b ec=%0d want e=1 ec=1", err_o, err_cnt_o);
        else passed++;
        err_clr_i = 1'b1;
        @(posedge clk); #1;
        err_clr_i = 1'b0;
        exp_err = 0;
        checks++;
        if (err_o !== 1'b0 || err_cnt_o !== 8'd0)
            $display("FAIL err_clear: got e=%b ec=%0d want e=0 ec=0", err_o, err_cnt_o);
        else passed++;
        check_scoreboard("illegal");
    endtask

    task automatic test_addr_wrap();
        bundle_t q[$];
        int cyc;
        load_i = 1'b1; base_addr_i = 32'hFFFF_FFF8;
        @(posedge clk); #1;
        load_i = 1'b0;
        exp_addr = 32'hFFFF_FFF8;
        for (int i = 0; i < 3; i++) q.push_back(mk(3'd0, 7'h33, 5'(i + 1), 5'd2, 5'd3, 3'd0, 7'd0, '0));
        drive_stream(q, 100, cyc);
        checks++;
        if (cyc != 3) $display("FAIL back_to_back_cycles: got %0d want 3", cyc);
        else passed++;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 3 || got_q[0].a !== 32'hFFFF_FFF8 || got_q[1].a !== 32'hFFFF_FFFC || got_q[2].a !== 32'h0)
            $display("FAIL addr_wrap: got %0d words, last addr %h want 3 words, last addr 00000000",
                     got_q.size(), (got_q.size() > 0) ? got_q[got_q.size() - 1].a : 32'hx);
        else passed++;
        check_scoreboard("addr_wrap");
    endtask

    task automatic test_load_priority();
        instr_ready_i = 1'b0;
        accept_one(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000));
        @(posedge clk); #1;
        load_i = 1'b1; base_addr_i = 32'h0000_1000; exp_addr = 32'h0000_1000;
        @(posedge clk); #1;
        base_addr_i = 32'h0000_2000; exp_addr = 32'h0000_2000; instr_ready_i = 1'b1;
        @(posedge clk); #1;
        load_i = 1'b0;
        accept_one(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8));
        check_scoreboard("load_priority");
    endtask

    task automatic test_backpressure();
        bundle_t     q[$];
        int          i = 0, acc_hold = 0;
        bit          acc, moved = 1'b0;
        logic [31:0] held = '0, held_a = '0;
        for (int k = 0; k < 6; k++) q.push_back(mk(3'd2, 7'h23, '0, 5'(k), 5'(k + 7), 3'd2, '0, 32'(k * 12 - 30)));
        for (int c = 0; c < 40 && (i < q.size()); c++) begin
            apply(q[i]);
            instr_ready_i = (c >= 5);
            @(negedge clk); acc = ready_o;
            if (c == 2) begin held = instr_o; held_a = instr_addr_o; end
            if (c > 2 && c < 5 && (instr_o !== held || instr_addr_o !== held_a || !instr_valid_o)) moved = 1'b1;
            if (c == 4) begin
                checks++;
                if (ready_o !== 1'b0) $display("FAIL bp_ready: got %b want 0", ready_o);
                else passed++;
            end
            @(posedge clk); #1;
            if (acc) begin on_accept(q[i]); i++; if (c < 5) acc_hold++; end
        end
        valid_i = 1'b0;
        checks++;
        if (acc_hold != 2) $display("FAIL bp_accepts: got %0d want 2", acc_hold);
        else passed++;
        checks++;
        if (moved) $display("FAIL bp_stable: got output change want stable %h", held);
        else passed++;
        check_scoreboard("backpressure");
    endtask

    task automatic test_random();
        bundle_t q[$];
        int cyc;
        for (int k = 0; k < 300; k++) q.push_back(rand_bundle());
        drive_stream(q, 70, cyc);
        check_scoreboard("random");
        checks++;
        if (err_cnt_o !== 8'(exp_err) || err_o !== (exp_err > 0))
            $display("FAIL random_err: got e=%b ec=%0d want e=%b ec=%0d", err_o, err_cnt_o, exp_err > 0, exp_err);
        else passed++;
    endtask

    task automatic test_err_saturate();
        bundle_t q[$];
        int cyc;
        for (int k = 0; k < 260; k++) q.push_back(mk(3'd7, 7'h33, '0, '0, '0, '0, '0, '0));
        drive_stream(q, 100, cyc);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err_cnt_o !== 8'hFF || exp_err != 255) $display("FAIL err_saturate: got %0d want 255", err_cnt_o);
        else passed++;
        check_scoreboard("err_sat");
    endtask

    task automatic test_reset_midflight();
        instr_ready_i = 1'b0;
        accept_one(mk(3'd0, 7'h33, 5'd9, 5'd8, 5'd7, 3'd1, 7'h20, '0));
        accept_one(mk(3'd1, 7'h03, 5'd4, 5'd3, 5'd0, 3'd2, 7'd0, 32'd16));
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_midflight");
        exp_q.delete(); got_q.delete();
        exp_addr = '0; exp_enc = 0; exp_err = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        instr_ready_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 0 || instr_valid_o !== 1'b0)
            $display("FAIL reset_no_stale: got %0d words v=%b want 0 words v=0", got_q.size(), instr_valid_o);
        else passed++;
        check_scoreboard("post_reset");
    endtask

    initial begin
        test_reset();
        test_directed("r_add", mk(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, '0), 32'h003100B3);
        test_directed("i_addi", mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF), 32'hFFF00093);
        test_illegal();
        test_directed("b_beq", mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC), 32'hFE208EE3);
        test_directed("j_jal", mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8), 32'h008000EF);
        test_directed("u_lui", mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000), 32'h123452B7);
        test_addr_wrap();
        test_load_priority();
        test_backpressure();
        test_random();
        test_err_saturate();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
